// File: rtl/ifid_skid_stage_if.sv
// Handshake/payload bundle between fetch, the IF/ID skid stage and decode.
// The stage side uses the slave modport; the driving environment uses master.
interface ifid_skid_stage_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 8
);
    logic             valid_i;
    logic [WIDTH-1:0] data_i;
    logic             ready_o;
    logic             valid_o;
    logic [WIDTH-1:0] data_o;
    logic             ready_i;
    logic             stall_i;
    logic             flush_i;
    logic [CNT_W-1:0] drop_cnt_o;

    modport slave (
        input  valid_i, data_i, ready_i, stall_i, flush_i,
        output ready_o, valid_o, data_o, drop_cnt_o
    );

    modport master (
        output valid_i, data_i, ready_i, stall_i, flush_i,
        input  ready_o, valid_o, data_o, drop_cnt_o
    );
endinterface

// File: rtl/ifid_skid_stage.sv
// Two-entry skid-buffered IF/ID stage: registered ready, hazard stall,
// flush with saturating discard counter.
module ifid_skid_stage #(
    parameter int unsigned WIDTH          = 64,
    parameter int unsigned CNT_W          = 8,
    parameter bit          CLEAR_ON_FLUSH = 1'b1
) (
    input logic              clk_i,
    input logic              rst_i,
    ifid_skid_stage_if.slave bus
);
    localparam int unsigned SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    // Encoding bit0 = main valid, bit1 = skid valid; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_MAIN  = 2'b01,
        S_FULL  = 2'b11
    } occ_e;

    occ_e             state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             take_c;
    logic             acc_c;
    logic [1:0]       held_c;
    logic [SUM_W-1:0] cnt_sum_c;

    assign take_c    = state_q[0] & bus.ready_i & ~bus.stall_i;
    assign acc_c     = bus.valid_i & ready_q & ~bus.flush_i;
    assign held_c    = {1'b0, state_q[0]} + {1'b0, state_q[1]};
    assign cnt_sum_c = {2'b00, cnt_q} + SUM_W'(held_c);

    // Next-state: flush overrides stall, take and accept.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;

        if (bus.flush_i) begin
            state_d = S_EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_d = '0;
                skid_d = '0;
            end
            cnt_d = (cnt_sum_c > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum_c[CNT_W-1:0];
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (acc_c) begin
                        main_d  = bus.data_i;
                        state_d = S_MAIN;
                    end
                end
                S_MAIN: begin
                    if (take_c) begin
                        if (acc_c) begin
                            main_d = bus.data_i;
                        end else begin
                            state_d = S_EMPTY;
                        end
                    end else if (acc_c) begin
                        skid_d  = bus.data_i;
                        state_d = S_FULL;
                    end
                end
                S_FULL: begin
                    // ready_q is low here, so nothing can be accepted alongside the drain.
                    if (take_c) begin
                        main_d  = skid_q;
                        state_d = S_MAIN;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end

        ready_d = (state_d != S_FULL);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.valid_o    = state_q[0];
    assign bus.data_o     = main_q;
    assign bus.ready_o    = ready_q;
    assign bus.drop_cnt_o = cnt_q;

    // The separately registered ready must always mirror skid occupancy.
    ready_tracks_skid: assert property (@(posedge clk_i) disable iff (rst_i)
        ready_q == (state_q != S_FULL));

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Bench for ifid_skid_stage: queue-based reference model checked every cycle
// on two instances (8-bit counter with clearing, 2-bit counter holding data).
module tb_ifid_skid_stage;
    localparam int unsigned WIDTH = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid_i = 1'b0;
    logic [WIDTH-1:0] data_i = '0;
    logic             ready_i = 1'b0;
    logic             stall_i = 1'b0;
    logic             flush_i = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ifid_skid_stage_if #(.WIDTH(WIDTH), .CNT_W(8)) bus_a ();
    ifid_skid_stage_if #(.WIDTH(WIDTH), .CNT_W(2)) bus_b ();

    assign bus_a.valid_i = valid_i;
    assign bus_a.data_i  = data_i;
    assign bus_a.ready_i = ready_i;
    assign bus_a.stall_i = stall_i;
    assign bus_a.flush_i = flush_i;
    assign bus_b.valid_i = valid_i;
    assign bus_b.data_i  = data_i;
    assign bus_b.ready_i = ready_i;
    assign bus_b.stall_i = stall_i;
    assign bus_b.flush_i = flush_i;

    ifid_skid_stage #(.WIDTH(WIDTH), .CNT_W(8), .CLEAR_ON_FLUSH(1'b1)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a)
    );

    ifid_skid_stage #(.WIDTH(WIDTH), .CNT_W(2), .CLEAR_ON_FLUSH(1'b0)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    // Reference model: ordered list of held payloads, at most two.
    logic [WIDTH-1:0] q[$];
    int unsigned      m_cnt_a = 0;
    int unsigned      m_cnt_b = 0;
    logic [WIDTH-1:0] m_data_a = '0;
    logic [WIDTH-1:0] m_data_b = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_cnt_a  = 0;
            m_cnt_b  = 0;
            m_data_a = '0;
            m_data_b = '0;
        end else if (flush_i) begin
            m_cnt_a  = (m_cnt_a + q.size() > 255) ? 255 : m_cnt_a + q.size();
            m_cnt_b  = (m_cnt_b + q.size() > 3) ? 3 : m_cnt_b + q.size();
            q.delete();
            m_data_a = '0;
        end else begin
            automatic bit t = (q.size() > 0) && ready_i && !stall_i;
            automatic bit a = valid_i && (q.size() < 2);
            if (t) void'(q.pop_front());
            if (a) q.push_back(data_i);
        end
        if (q.size() > 0) begin
            m_data_a = q[0];
            m_data_b = q[0];
        end
    end

    always @(negedge clk) begin
        chk("valid_a", 64'(bus_a.valid_o), 64'(q.size() > 0));
        chk("ready_a", 64'(bus_a.ready_o), 64'(q.size() < 2));
        chk("data_a",  bus_a.data_o, m_data_a);
        chk("cnt_a",   64'(bus_a.drop_cnt_o), 64'(m_cnt_a));
        chk("valid_b", 64'(bus_b.valid_o), 64'(q.size() > 0));
        chk("ready_b", 64'(bus_b.ready_o), 64'(q.size() < 2));
        chk("data_b",  bus_b.data_o, m_data_b);
        chk("cnt_b",   64'(bus_b.drop_cnt_o), 64'(m_cnt_b));
    end

    task automatic cyc(input logic v, input logic [63:0] d, input logic r,
                       input logic s, input logic f);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        stall_i = s;
        flush_i = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus_a.valid_o), 64'd0);
        chk("rst_ready", 64'(bus_a.ready_o), 64'd1);
        chk("rst_data",  bus_a.data_o, 64'd0);
        chk("rst_cnt",   64'(bus_a.drop_cnt_o), 64'd0);
        rst = 1'b0;

        // Streaming at full rate
        cyc(1, 64'hA1, 1, 0, 0);
        chk("a1_data", bus_a.data_o, 64'hA1);
        chk("a1_valid", 64'(bus_a.valid_o), 64'd1);
        cyc(1, 64'hA2, 1, 0, 0);
        chk("a2_data", bus_a.data_o, 64'hA2);
        cyc(1, 64'hA3, 1, 0, 0);
        cyc(1, 64'hA4, 1, 0, 0);
        chk("a4_data", bus_a.data_o, 64'hA4);
        chk("a4_ready", 64'(bus_a.ready_o), 64'd1);
        cyc(0, 64'h0, 1, 0, 0);
        chk("a_idle_valid", 64'(bus_a.valid_o), 64'd0);
        chk("a_idle_data", bus_a.data_o, 64'hA4);

        // Back-pressure fills the skid
        cyc(1, 64'hB1, 0, 0, 0);
        cyc(1, 64'hB2, 0, 0, 0);
        chk("b2_ready", 64'(bus_a.ready_o), 64'd0);
        cyc(1, 64'hB3, 0, 0, 0);
        chk("b3_held_data", bus_a.data_o, 64'hB1);
        cyc(1, 64'hB3, 1, 0, 0);
        chk("b_drain_data", bus_a.data_o, 64'hB2);
        chk("b_drain_ready", 64'(bus_a.ready_o), 64'd1);
        cyc(1, 64'hB3, 1, 0, 0);
        chk("b3_data", bus_a.data_o, 64'hB3);
        cyc(0, 64'h0, 1, 0, 0);

        // Stall freezes output while upstream fills the skid
        cyc(1, 64'hC1, 1, 0, 0);
        cyc(1, 64'hC2, 1, 1, 0);
        cyc(0, 64'h0, 1, 1, 0);
        cyc(0, 64'h0, 1, 1, 0);
        chk("c_stall_data", bus_a.data_o, 64'hC1);
        chk("c_stall_ready", 64'(bus_a.ready_o), 64'd0);
        cyc(0, 64'h0, 1, 0, 0);
        chk("c2_data", bus_a.data_o, 64'hC2);
        cyc(0, 64'h0, 1, 0, 0);

        // Flush of a full stage with stall and valid input
        cyc(1, 64'hD1, 0, 0, 0);
        cyc(1, 64'hD2, 0, 0, 0);
        cyc(1, 64'hD3, 0, 1, 1);
        chk("d_fl_valid", 64'(bus_a.valid_o), 64'd0);
        chk("d_fl_ready", 64'(bus_a.ready_o), 64'd1);
        chk("d_fl_data_a", bus_a.data_o, 64'd0);
        chk("d_fl_data_b", bus_b.data_o, 64'hD1);
        chk("d_fl_cnt_a", 64'(bus_a.drop_cnt_o), 64'd2);
        chk("d_fl_cnt_b", 64'(bus_b.drop_cnt_o), 64'd2);
        cyc(0, 64'h0, 1, 0, 0);
        chk("d3_dropped", 64'(bus_a.valid_o), 64'd0);

        // Saturation of the 2-bit counter
        cyc(1, 64'hE1, 0, 0, 0);
        cyc(1, 64'hE2, 0, 0, 0);
        cyc(0, 64'h0, 0, 0, 1);
        chk("e_cnt_a", 64'(bus_a.drop_cnt_o), 64'd4);
        chk("e_cnt_b", 64'(bus_b.drop_cnt_o), 64'd3);
        cyc(1, 64'hF1, 0, 0, 0);
        cyc(0, 64'h0, 0, 0, 1);
        chk("f_cnt_a", 64'(bus_a.drop_cnt_o), 64'd5);
        chk("f_cnt_b", 64'(bus_b.drop_cnt_o), 64'd3);

        // Flush beats simultaneous take and accept
        cyc(1, 64'hA0A1, 1, 0, 0);
        cyc(1, 64'hA0A2, 1, 0, 1);
        chk("g_fl_valid", 64'(bus_a.valid_o), 64'd0);
        chk("g_fl_cnt_a", 64'(bus_a.drop_cnt_o), 64'd6);
        chk("g_fl_data_b", bus_b.data_o, 64'hA0A1);
        cyc(0, 64'h0, 1, 0, 0);

        // Asynchronous reset with both entries full
        cyc(1, 64'h11, 0, 0, 0);
        cyc(1, 64'h12, 0, 0, 0);
        valid_i = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("ar_valid", 64'(bus_a.valid_o), 64'd0);
        chk("ar_ready", 64'(bus_a.ready_o), 64'd1);
        chk("ar_data", bus_a.data_o, 64'd0);
        chk("ar_cnt_a", 64'(bus_a.drop_cnt_o), 64'd0);
        chk("ar_cnt_b", 64'(bus_b.drop_cnt_o), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1, 64'h21, 1, 0, 0);
        chk("j1_data", bus_a.data_o, 64'h21);
        chk("j1_valid", 64'(bus_a.valid_o), 64'd1);
        cyc(1, 64'h22, 1, 0, 0);
        chk("j2_data", bus_a.data_o, 64'h22);
        cyc(0, 64'h0, 1, 0, 0);
        cyc(0, 64'h0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
